// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix scanner: double-buffered frame load, per-row blanking, 16-level PWM.
// Optional build macro MATRIX_FRAME_CNT_EN adds a free-running 16-bit frame counter output.
module matrix_scan_driver #(
    parameter int ROWS  = 8,
    parameter int COLS  = 16,
    parameter int DIV   = 1024,
    parameter int BLANK = 16,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int SLOT_W = $clog2(DIV)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 frame_load,
    output logic                 frame_ack,
    input  logic                 enable,
    input  logic [3:0]           brightness,
    output logic [ROWS-1:0]      matrix_row,
    output logic [COLS-1:0]      matrix_col,
    output logic [ROW_W-1:0]     row_idx,
`ifdef MATRIX_FRAME_CNT_EN
    output logic [15:0]          frame_cnt,
`endif
    output logic                 frame_start
);

    logic [SLOT_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [ROW_W-1:0]     row_idx_q, row_idx_d;
    logic [ROWS*COLS-1:0] display_q, display_d;
    logic [ROWS*COLS-1:0] pending_q, pending_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [ROWS-1:0]      matrix_row_q, matrix_row_d;
    logic [COLS-1:0]      matrix_col_q, matrix_col_d;
    logic                 frame_ack_q, frame_ack_d;
    logic                 frame_start_q, frame_start_d;

    logic                 boundary;
    logic                 boundary_next;
    logic                 lit;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_sel;

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        row_idx_d  = row_idx_q;
        if (slot_cnt_q == SLOT_W'(DIV - 1)) begin
            slot_cnt_d = '0;
            if (row_idx_q == ROW_W'(ROWS - 1)) begin
                row_idx_d = '0;
            end else begin
                row_idx_d = row_idx_q + 1'b1;
            end
        end
    end

    assign boundary      = (slot_cnt_q == '0) && (row_idx_q == '0);
    assign boundary_next = (slot_cnt_d == '0) && (row_idx_d == '0);

    // Transfer reads the old pending contents, so a load on the boundary cycle waits a frame.
    always_comb begin
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (boundary && pending_valid_q) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end
        if (frame_load) begin
            pending_d       = frame_in;
            pending_valid_d = 1'b1;
        end
    end

    // Pulses are registered from the next state so they line up with the boundary cycle itself.
    always_comb begin
        frame_start_d = boundary_next;
        frame_ack_d   = boundary_next && pending_valid_d;
    end

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx_q == ROW_W'(r)) begin
                row_sel[r] = 1'b1;
                col_sel    = display_q[r*COLS +: COLS];
            end
        end
    end

    assign lit = enable && (slot_cnt_q >= SLOT_W'(BLANK)) && (slot_cnt_q[3:0] <= brightness);

    always_comb begin
        matrix_row_d = '1;
        matrix_col_d = '1;
        if (lit) begin
            matrix_row_d = ~row_sel;
            matrix_col_d = ~col_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q      <= '0;
            row_idx_q       <= '0;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            matrix_row_q    <= '1;
            matrix_col_q    <= '1;
            frame_ack_q     <= 1'b0;
            frame_start_q   <= 1'b0;
        end else begin
            slot_cnt_q      <= slot_cnt_d;
            row_idx_q       <= row_idx_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            matrix_row_q    <= matrix_row_d;
            matrix_col_q    <= matrix_col_d;
            frame_ack_q     <= frame_ack_d;
            frame_start_q   <= frame_start_d;
        end
    end

`ifdef MATRIX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign matrix_row  = matrix_row_q;
    assign matrix_col  = matrix_col_q;
    assign row_idx     = row_idx_q;
    assign frame_ack   = frame_ack_q;
    assign frame_start = frame_start_q;

endmodule
